clk_div_ctrl: RTL
=================

// Module: clk_div_ctrl
// PURPOSE
//   Run-time controller for the VGA clock-enable path. Holds the active divide ratio and
//   produces a divided clock (clk_out) plus a one-cycle enable strobe (tick) from clk.
//   Accepts new ratios over a valid/ready handshake and applies them only at a period
//   boundary, so clk_out never glitches. Sits between mode/config logic and the pixel pipeline.
// PARAMETERS
//   DIV_W        16   width of the divide ratio and of the internal counter
//   DEFAULT_DIV  4    ratio loaded at reset (100 MHz -> 25 MHz pixel rate); must be >= 2
// PORTS
//   clk        in   1      single system clock; all logic on its rising edge
//   rst        in   1      synchronous, active-high reset
//   run        in   1      level: 1 = generate clk_out/tick, 0 = stop at the next period end
//   cfg_div    in   DIV_W  requested divide ratio; legal range is 2 .. 2^DIV_W-1
//   cfg_valid  in   1      cfg_div is valid
//   cfg_ready  out  1      controller can accept cfg_div this cycle
//   cfg_err    out  1      one-cycle pulse: an accepted request had cfg_div < 2 and was dropped
//   clk_out    out  1      divided clock, registered
//   tick       out  1      one-cycle strobe on the first cycle of each clk_out period, registered
//   active     out  1      1 while the state is RUN or PEND
//   div_cur    out  DIV_W  ratio currently in force
// BEHAVIOUR
//   Reset: state=IDLE, cnt=0, div_cur=DEFAULT_DIV, clk_out=0, tick=0, cfg_ready=1,
//   cfg_err=0, active=0. Any pending ratio is discarded.
//   States: IDLE (stopped), RUN (counting), PEND (counting; new ratio held in pend_div).
//   Counter: in RUN/PEND, cnt steps 0..div_cur-1 and wraps to 0. hi = (div_cur+1)>>1.
//   Outputs are registered and aligned with cnt: tick=1 iff the state is RUN/PEND and cnt==0;
//   clk_out=1 iff the state is RUN/PEND and cnt<hi. Both are 0 in IDLE. Odd ratios give a
//   longer high phase (5 -> 3 high, 2 low).
//   IDLE -> RUN: if run=1 at cycle t, then at t+1 state=RUN, cnt=0, tick=1, clk_out=1.
//   Handshake: accept = cfg_valid & cfg_ready. cfg_ready=1 in IDLE and RUN, 0 in PEND.
//   - Accepted cfg_div < 2: pulse cfg_err for one cycle; no other state changes.
//   - Legal accept in IDLE: div_cur <= cfg_div on the next cycle.
//   - Legal accept in RUN: pend_div <= cfg_div, state -> PEND. The counter continues with the
//     old ratio.
//   - PEND at end of period (cnt == div_cur-1): div_cur <= pend_div, cnt <= 0,
//     state -> RUN (or IDLE if run=0).
//   - Accept on the same cycle as the end of a period in RUN: the ratio is applied at the
//     next period end, not immediately.
//   Stop: if run=0 in RUN/PEND, the current period finishes. At cnt == div_cur-1 the state
//   goes to IDLE. A ratio pending in PEND is applied on that same transition. If run returns
//   to 1 before the period ends, there is no stop.
//   The ratio never changes within a period, and the low phase is never shortened.
//   rst during RUN/PEND: all registers return to their reset values on the next edge.
// STRUCTURE
//   Shared header clk_div_defs.vh: state encodings ST_IDLE/ST_RUN/ST_PEND, DIV_W, DEFAULT_DIV.
//   Sub-module clk_div_counter (inputs: clk, rst, en, div; outputs: wrap, tick, clk_out)
//   holds the counter and output registers. The top level holds the FSM, handshake and
//   div_cur/pend_div.
// TESTING
//   1) rst=1 for 2 cycles, then release -> clk_out=0, tick=0, cfg_ready=1, div_cur=4, active=0.
//   2) run=1 at cycle t with DIV=4 -> clk_out is 1,1,0,0 repeating from t+1; tick is high at
//      t+1, t+5, t+9, ...
//   3) In IDLE, send cfg_div=5, then run=1 -> clk_out is 3 cycles high, 2 low; div_cur=5.
//   4) Running at 4, send cfg_div=8 at cnt=1 -> cfg_ready=0 until the period ends, active
//      stays 1; the next period is 8 cycles long (4 high, 4 low) with tick at its start.
//   5) Send cfg_div=1 with cfg_valid=1 -> cfg_err is high for exactly 1 cycle, div_cur is
//      unchanged, cfg_ready stays 1.
//   6) With run=0 at cnt=1 (DIV=4), the period completes, then clk_out=0 and active=0.
//      Separately, assert rst while in PEND -> pend_div is dropped and div_cur=DEFAULT_DIV.

Source files
------------

// File: rtl/clk_div_ctrl_pkg.sv
// Shared constants and state encoding for the clock-divider controller.
package clk_div_ctrl_pkg;

   // Default counter/ratio width and the ratio loaded at reset.
   localparam int DEF_DIV_W       = 16;
   localparam int DEF_DEFAULT_DIV = 4;

   // Smallest divide ratio that still produces a toggling clk_out.
   localparam int MIN_DIV = 2;

   // IDLE: stopped. RUN: counting. PEND: counting with a new ratio waiting for the period end.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_PEND = 2'd2
   } state_e;

endpackage

// File: rtl/clk_div_ctrl_counter.sv
// Period counter and registered clk_out/tick outputs for the clock divider.
// The counter runs 0..div-1 while enabled; outputs are registered alongside cnt.
module clk_div_ctrl_counter
   import clk_div_ctrl_pkg::*;
#(
   parameter int DIV_W = DEF_DIV_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,       // next cycle is a counting cycle
   input  logic [DIV_W-1:0] div,      // ratio in force for the current period
   output logic             wrap,     // current cycle is the last one of the period
   output logic             tick,
   output logic             clk_out
);

   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic             en_q;
   logic             tick_q, tick_d;
   logic             clk_out_q, clk_out_d;
   logic [DIV_W:0]   hi;

   assign wrap    = en_q && (cnt_q == (div - DIV_W'(1)));
   assign tick    = tick_q;
   assign clk_out = clk_out_q;

   // Next count and next output levels; a fresh period always starts at cnt 0,
   // and cnt 0 is always in the high phase, so a ratio change at a period
   // boundary never affects the first cycle of the new period.
   always_comb begin
      hi        = ({1'b0, div} + (DIV_W + 1)'(1)) >> 1;
      cnt_d     = '0;
      tick_d    = 1'b0;
      clk_out_d = 1'b0;
      if (en && en_q && !wrap) begin
         cnt_d = cnt_q + DIV_W'(1);
      end
      if (en) begin
         tick_d    = (cnt_d == '0);
         clk_out_d = ({1'b0, cnt_d} < hi);
      end
   end

   // Counter and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= '0;
         en_q      <= 1'b0;
         tick_q    <= 1'b0;
         clk_out_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         en_q      <= en;
         tick_q    <= tick_d;
         clk_out_q <= clk_out_d;
      end
   end

endmodule

// File: rtl/clk_div_ctrl.sv
// Run-time clock-divider controller: holds the active ratio, accepts new ratios
// over valid/ready and applies them only at a period boundary.
// Handshake: a request is taken on a rising edge where cfg_valid && cfg_ready;
// cfg_ready depends only on the current state (low while a ratio is pending).
module clk_div_ctrl
   import clk_div_ctrl_pkg::*;
#(
   parameter int DIV_W       = DEF_DIV_W,
   parameter int DEFAULT_DIV = DEF_DEFAULT_DIV
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic [DIV_W-1:0] cfg_div,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   output logic             cfg_err,
   output logic             clk_out,
   output logic             tick,
   output logic             active,
   output logic [DIV_W-1:0] div_cur,
   output state_e           state_dbg
);

   state_e           state_q, state_d;
   logic [DIV_W-1:0] div_cur_q, div_cur_d;
   logic [DIV_W-1:0] pend_div_q, pend_div_d;
   logic             cfg_err_q, cfg_err_d;
   logic             accept, legal, wrap, cnt_en;

   assign cfg_ready = (state_q != ST_PEND);
   assign active    = (state_q != ST_IDLE);
   assign cfg_err   = cfg_err_q;
   assign div_cur   = div_cur_q;
   assign state_dbg = state_q;
   assign accept    = cfg_valid && cfg_ready;
   assign legal     = (cfg_div >= DIV_W'(MIN_DIV));
   assign cnt_en    = (state_d != ST_IDLE);

   // Next-state, handshake and ratio bookkeeping.
   always_comb begin
      state_d    = state_q;
      div_cur_d  = div_cur_q;
      pend_div_d = pend_div_q;
      cfg_err_d  = accept && !legal;
      case (state_q)
         ST_IDLE: begin
            if (accept && legal) begin
               div_cur_d = cfg_div;
            end
            if (run) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (wrap && !run) begin
               // Stopping: nothing runs afterwards, so a ratio taken now is simply loaded.
               state_d = ST_IDLE;
               if (accept && legal) begin
                  div_cur_d = cfg_div;
               end
            end else if (accept && legal) begin
               // Even on a period's last cycle the new ratio waits a full period.
               pend_div_d = cfg_div;
               state_d    = ST_PEND;
            end
         end
         ST_PEND: begin
            if (wrap) begin
               div_cur_d = pend_div_q;
               state_d   = run ? ST_RUN : ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Control registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         div_cur_q  <= DIV_W'(DEFAULT_DIV);
         pend_div_q <= '0;
         cfg_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         div_cur_q  <= div_cur_d;
         pend_div_q <= pend_div_d;
         cfg_err_q  <= cfg_err_d;
      end
   end

   clk_div_ctrl_counter #(
      .DIV_W (DIV_W)
   ) u_counter (
      .clk     (clk),
      .rst     (rst),
      .en      (cnt_en),
      .div     (div_cur_q),
      .wrap    (wrap),
      .tick    (tick),
      .clk_out (clk_out)
   );

endmodule
